// File: rtl/pipe_if_stage.sv
// ---------------------------------------------------------------------------
// pipe_if_stage -- instruction-fetch stage of an in-order pipeline.
//
// Issues one fetch at a time to the instruction memory and presents the
// fetched word to the IF/ID register. A fetch that completes while the IF/ID
// register is stalled is parked in inst_q until the register accepts it.
//
// Optional feature: define PIPE_IF_PERF_CNT_EN to build the fetch/stall
// performance counters; otherwise fetch_cnt and stall_cnt read as 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   nostall           1 = IF/ID register accepts the presented instruction
//   pcsource          next-PC select: 00 pc4, 01 bpc, 10 rpc, 11 jpc
//   bpc, rpc, jpc     branch / jump-register / jump targets
//   imem_rdata        instruction memory read data
//   imem_ready        instruction memory completes the request this cycle
//   imem_req          fetch request
//   imem_addr         fetch address (always equal to pc)
//   pc, pc4           current fetch PC and pc + 4 (wraps modulo 2^32)
//   inst              instruction for IF/ID (NOP_INST whenever if_valid = 0)
//   if_valid          inst holds a real fetched instruction
//   fetch_cnt         advancing-cycle counter
//   stall_cnt         stall-cycle counter (nostall = 0 outside WAIT)
//
// Handshake: a memory transfer completes in a cycle where imem_req = 1 and
// imem_ready = 1; the IF/ID register takes inst in a cycle where
// if_valid = 1 and nostall = 1. The PC advances exactly in that cycle.
// ---------------------------------------------------------------------------
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        if_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] next_pc;
  logic        advance;
  logic        capture;

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign pc4       = pc_q + 32'd4;

  // Target selection is free-running; it only matters in the advance cycle.
  always_comb begin
    next_pc = pc4;
    case (pcsource)
      2'b00:   next_pc = pc4;
      2'b01:   next_pc = bpc;
      2'b10:   next_pc = rpc;
      2'b11:   next_pc = jpc;
      default: next_pc = pc4;
    endcase
  end

  // State register, PC and parked instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_WAIT;
      pc_q   <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      state <= state_next;
      if (advance) begin
        pc_q <= next_pc;
      end
      if (capture) begin
        inst_q <= imem_rdata;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    inst       = NOP_INST;
    advance    = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_WAIT: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          // Zero-latency bypass of the memory word to IF/ID.
          if_valid = 1'b1;
          inst     = imem_rdata;
          if (nostall) begin
            advance = 1'b1;
          end else begin
            // IF/ID is stalled: park the word so the fetch is not repeated.
            capture    = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if_valid = 1'b1;
        inst     = inst_q;
        if (nostall) begin
          advance    = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

`ifdef PIPE_IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (advance) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (!nostall && (state != ST_WAIT)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_stage -- self-checking bench for pipe_if_stage.
// Directed vector table, hand-written corner sequences (pc4 wrap,
// asynchronous reset mid-HOLD) and a randomized run against a reference
// model that tracks "started", a parked-instruction queue and the PC.
// ---------------------------------------------------------------------------
module tb_pipe_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc, imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr, pc, pc4, inst, fetch_cnt, stall_cnt;
  logic        if_valid;

  pipe_if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .nostall    (nostall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc4        (pc4),
    .inst       (inst),
    .if_valid   (if_valid),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_started;
  logic [31:0] m_held[$];   // instruction waiting for IF/ID to accept it
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic model_reset();
    m_started = 1'b0;
    m_held.delete();
    m_pc    = RESET_PC;
    m_fetch = 32'd0;
    m_stall = 32'd0;
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef PIPE_IF_PERF_CNT_EN
    return v;
`else
    return 32'd0 + (v & 32'd0);
`endif
  endfunction

  task automatic drive(input logic ns, input logic [1:0] src, input logic rdy,
                       input logic [31:0] rd, input logic [31:0] b,
                       input logic [31:0] r, input logic [31:0] j);
    nostall = ns; pcsource = src; imem_ready = rdy;
    imem_rdata = rd; bpc = b; rpc = r; jpc = j;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at negedge, compare mid-cycle, advance the model.
  task automatic step(input logic ns, input logic [1:0] src, input logic rdy,
                      input logic [31:0] rd, input logic [31:0] b,
                      input logic [31:0] r, input logic [31:0] j);
    logic        e_req, e_val, adv;
    logic [31:0] e_inst, nxt;
    @(negedge clk);
    drive(ns, src, rdy, rd, b, r, j);
    #1;
    nxt = (src == 2'd0) ? m_pc + 32'd4 : (src == 2'd1) ? b : (src == 2'd2) ? r : j;
    e_req = 1'b0; e_val = 1'b0; e_inst = NOP; adv = 1'b0;
    if (!m_started) begin
      // first cycle after reset: idle
    end else if (m_held.size() != 0) begin
      e_val = 1'b1; e_inst = m_held[0]; adv = ns;
    end else begin
      e_req = 1'b1;
      if (rdy) begin
        e_val = 1'b1; e_inst = rd; adv = ns;
      end
    end
    check("m_req",   {31'd0, imem_req}, {31'd0, e_req});
    check("m_valid", {31'd0, if_valid}, {31'd0, e_val});
    check("m_inst",  inst, e_inst);
    check("m_pc",    pc, m_pc);
    check("m_addr",  imem_addr, m_pc);
    check("m_pc4",   pc4, m_pc + 32'd4);
    check("m_fcnt",  fetch_cnt, cnt_exp(m_fetch));
    check("m_scnt",  stall_cnt, cnt_exp(m_stall));
    if (m_started && !ns) m_stall = m_stall + 32'd1;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held.size() != 0) begin
      if (ns) void'(m_held.pop_front());
    end else if (rdy && !ns) begin
      m_held.push_back(rd);
    end
    if (adv) begin
      m_pc    = nxt;
      m_fetch = m_fetch + 32'd1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ns;
    logic [1:0]  src;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_val;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 32'hA0,   1'b0, 1'b0, NOP,    32'h000};
    tbl[1]  = '{1'b1, 2'd0, 1'b1, 32'hA1,   1'b1, 1'b1, 32'hA1, 32'h000};
    tbl[2]  = '{1'b1, 2'd0, 1'b1, 32'hA2,   1'b1, 1'b1, 32'hA2, 32'h004};
    tbl[3]  = '{1'b1, 2'd0, 1'b1, 32'hA3,   1'b1, 1'b1, 32'hA3, 32'h008};
    tbl[4]  = '{1'b1, 2'd0, 1'b1, 32'hA4,   1'b1, 1'b1, 32'hA4, 32'h00C};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'hB0,   1'b1, 1'b1, 32'hB0, 32'h010};
    tbl[6]  = '{1'b0, 2'd3, 1'b1, 32'hDEAD, 1'b0, 1'b1, 32'hB0, 32'h010};
    tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'hBEEF, 1'b0, 1'b1, 32'hB0, 32'h010};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 32'h55,   1'b0, 1'b1, 32'hB0, 32'h010};
    tbl[9]  = '{1'b1, 2'd0, 1'b1, 32'hC1,   1'b1, 1'b1, 32'hC1, 32'h014};
    tbl[10] = '{1'b1, 2'd0, 1'b1, 32'hC2,   1'b1, 1'b1, 32'hC2, 32'h018};
    tbl[11] = '{1'b1, 2'd0, 1'b1, 32'hC3,   1'b1, 1'b1, 32'hC3, 32'h01C};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'hEE,   1'b1, 1'b0, NOP,    32'h020};
    tbl[13] = '{1'b0, 2'd3, 1'b0, 32'hEF,   1'b1, 1'b0, NOP,    32'h020};
    tbl[14] = '{1'b1, 2'd1, 1'b1, 32'hC4,   1'b1, 1'b1, 32'hC4, 32'h020};
    tbl[15] = '{1'b1, 2'd2, 1'b1, 32'hC5,   1'b1, 1'b1, 32'hC5, 32'h100};
    tbl[16] = '{1'b1, 2'd3, 1'b1, 32'hC6,   1'b1, 1'b1, 32'hC6, 32'h200};
    tbl[17] = '{1'b0, 2'd1, 1'b1, 32'hC7,   1'b1, 1'b1, 32'hC7, 32'h300};
    tbl[18] = '{1'b1, 2'd0, 1'b1, 32'hD0,   1'b0, 1'b1, 32'hC7, 32'h300};
    tbl[19] = '{1'b1, 2'd0, 1'b0, 32'hD1,   1'b1, 1'b0, NOP,    32'h304};
  end

  // ---------------- test sequence ----------------
  initial begin
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    // Reset state
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_inst",  inst, NOP);
    check("rst_pc",    pc, RESET_PC);
    check("rst_pc4",   pc4, RESET_PC + 32'd4);
    check("rst_fcnt",  fetch_cnt, 32'd0);
    check("rst_scnt",  stall_cnt, 32'd0);

    // Directed table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].ns, tbl[i].src, tbl[i].rdy, tbl[i].rdata,
            32'h100, 32'h200, 32'h300);
      #1;
      check($sformatf("tbl%0d_req", i),   {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      check($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_val});
      check($sformatf("tbl%0d_inst", i),  inst, tbl[i].e_inst);
      check($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].e_pc);
    end
`ifdef PIPE_IF_PERF_CNT_EN
    check("tbl_fcnt", fetch_cnt, 32'd12);
    check("tbl_scnt", stall_cnt, 32'd5);
`else
    check("tbl_fcnt", fetch_cnt, 32'd0);
    check("tbl_scnt", stall_cnt, 32'd0);
`endif

    // pc4 wrap at the top of the address space
    do_reset();
    step(1'b1, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0, 32'h0);
    step(1'b1, 2'd3, 1'b1, 32'h12, 32'h0, 32'h0, 32'hFFFF_FFFC);
    step(1'b1, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0, 32'h0);
    check("wrap_pc4", pc4, 32'h0000_0000);
    step(1'b1, 2'd0, 1'b1, 32'h14, 32'h0, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Asynchronous reset in the middle of HOLD
    do_reset();
    step(1'b1, 2'd0, 1'b1, 32'h21, 32'h0, 32'h0, 32'h0);
    step(1'b1, 2'd3, 1'b1, 32'h22, 32'h0, 32'h0, 32'h40);
    step(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h0, 32'h0);
    step(1'b0, 2'd1, 1'b0, 32'h24, 32'h80, 32'h0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_req",   {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_inst",  inst, NOP);
    check("arst_pc",    pc, RESET_PC);
    check("arst_pc4",   pc4, RESET_PC + 32'd4);
    check("arst_fcnt",  fetch_cnt, 32'd0);
    check("arst_scnt",  stall_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, 2'd0, 1'b1, 32'h31, 32'h0, 32'h0, 32'h0);
    step(1'b1, 2'd0, 1'b1, 32'h32, 32'h0, 32'h0, 32'h0);
    check("arst_first_addr", imem_addr, RESET_PC);

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom,
           $urandom, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000, giving the bubble instruction emitted when no valid fetch is available.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 nostall  input  1  downstream IF/ID register enable from the hazard unit; 1 = the IF/ID register accepts this cycle.
REQ-006 pcsource  input  2  next-PC select: 00 = pc4, 01 = bpc, 10 = rpc, 11 = jpc.
REQ-007 bpc  input  32  branch target.
REQ-008 rpc  input  32  jump-register target.
REQ-009 jpc  input  32  jump target.
REQ-010 imem_rdata  input  32  instruction memory read data, valid when imem_ready=1.
REQ-011 imem_ready  input  1  instruction memory completes the current request this cycle.
REQ-012 imem_req  output  1  fetch request.
REQ-013 imem_addr  output  32  fetch address; always equal to pc.
REQ-014 pc  output  32  current fetch PC.
REQ-015 pc4  output  32  pc + 4, modulo 2^32; feeds the IF/ID pc4 input.
REQ-016 inst  output  32  instruction for the IF/ID register.
REQ-017 if_valid  output  1  inst holds a real fetched instruction this cycle.
REQ-018 fetch_cnt  output  32  retired-fetch counter.
REQ-019 stall_cnt  output  32  stall-cycle counter.

Function
REQ-020 SHALL implement a 3-state FSM: WAIT (reset state), FETCH, HOLD.
REQ-021 WAIT: imem_req=0 and if_valid=0; SHALL go to FETCH unconditionally on the next edge.
REQ-022 FETCH: imem_req=1. When imem_ready=0, the block SHALL stay in FETCH with pc unchanged.
REQ-023 FETCH with imem_ready=1 and nostall=1: if_valid=1 and inst=imem_rdata in the same cycle (zero-latency bypass); pc SHALL load next_pc and the block SHALL stay in FETCH.
REQ-024 FETCH with imem_ready=1 and nostall=0: the block SHALL capture imem_rdata into inst_q, go to HOLD, and leave pc unchanged.
REQ-025 HOLD: imem_req=0, if_valid=1, inst=inst_q. With nostall=1, pc SHALL load next_pc and the block SHALL go to FETCH. With nostall=0, the block SHALL stay in HOLD.
REQ-026 Whenever if_valid=0, inst SHALL equal NOP_INST, so that the IF/ID register loads a bubble.
REQ-027 next_pc SHALL be selected combinationally by pcsource, sampled only in the advancing cycle; pcsource in non-advancing cycles SHALL be ignored.
REQ-028 pc4 SHALL wrap: pc=32'hFFFF_FFFC gives pc4=32'h0000_0000.
REQ-029 Sustained throughput with imem_ready tied to 1 and nostall tied to 1 SHALL be one instruction per cycle after the WAIT cycle.
REQ-030 imem_rdata SHALL be ignored whenever imem_ready=0 or the state is not FETCH.

Reset
REQ-031 On rst=1 the block SHALL immediately, without waiting for clk, force state=WAIT, pc=RESET_PC, inst_q=NOP_INST, and both counters to 0.
REQ-032 During reset the outputs SHALL be: imem_req=0, if_valid=0, inst=NOP_INST, pc4=RESET_PC+4.
REQ-033 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the outstanding fetch; the first request after release SHALL be to RESET_PC.

Configuration
REQ-034 Macro PIPE_IF_PERF_CNT_EN SHALL control the performance counters.
REQ-035 With the macro defined: fetch_cnt SHALL increment on every advancing cycle (REQ-023 or the HOLD advance), and stall_cnt SHALL increment on every cycle with nostall=0 outside WAIT. Both counters SHALL wrap at 2^32.
REQ-036 Without the macro, fetch_cnt and stall_cnt SHALL be constant 0 and no counter flops SHALL be inferred; all other behaviour SHALL be identical.

Verification
REQ-037 Reset release, with imem_ready=1 and nostall=1: cycle 0 imem_req=0; cycle 1 imem_addr=0x0; cycle 2 imem_addr=0x4; cycle 3 imem_addr=0x8; if_valid=1 from cycle 1 onward.
REQ-038 pc=0x10, imem_ready=1, nostall=0 for 3 cycles, then 1: HOLD for 3 cycles with inst constant, imem_req=0, pc=0x10; on the advance pc=0x14. With the macro defined, stall_cnt=3 and fetch_cnt=+1.
REQ-039 pc=0x20 held in FETCH with imem_ready=0 for 2 cycles: if_valid=0, inst=NOP_INST, pc stays 0x20; ready on the 3rd cycle delivers imem_rdata.
REQ-040 Advance with pcsource=01, bpc=0x100 -> pc=0x100. Same with pcsource=10, rpc=0x200 -> pc=0x200, and pcsource=11, jpc=0x300 -> pc=0x300. pcsource toggled while in HOLD SHALL have no effect.
REQ-041 pc=0xFFFF_FFFC, pcsource=00, advance -> pc4 before the advance is 0x0 and pc after it is 0x0.
REQ-042 rst pulsed asynchronously mid-HOLD -> outputs reset before the next clk edge, and the first request after release goes to RESET_PC.
